tpu_operand_loader: RTL and testbench
=====================================

Name: tpu_operand_loader

Overview:
- Upstream feeder for the TPU systolic core.
- Accepts a job descriptor (K, M, N) and a byte stream carrying matrix A (M×K) followed by matrix B (K×N).
- Packs the bytes into the 32-bit tiled layout the TPU reads, and writes them into the A and B buffers.
- Then issues the TPU start pulse and holds until the TPU drops busy, at which point it reports done.

Parameters:
- IDX_W, 16, width of buffer index outputs.
- START_TIMEOUT, 64, max cycles to wait for tpu_busy to rise after tpu_in_valid before flagging err.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  job descriptor valid.
- cfg_ready  out  1  high only in IDLE.
- cfg_K  in  8  inner dimension.
- cfg_M  in  8  rows of A.
- cfg_N  in  8  columns of B.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  high in LOAD_A/LOAD_B.
- s_data  in  8  stream byte.
- A_wr_en  out  1  A buffer write strobe.
- A_index  out  IDX_W  A buffer word address.
- A_data_in  out  32  packed A word.
- B_wr_en  out  1  B buffer write strobe.
- B_index  out  IDX_W  B buffer word address.
- B_data_in  out  32  packed B word.
- tpu_in_valid  out  1  one-cycle TPU start pulse.
- tpu_K, tpu_M, tpu_N  out  8 each  latched dims, stable from START until DONE.
- tpu_busy  in  1  TPU busy.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = zero dimension or TPU start timeout.

Behaviour:
- Reset: state=IDLE; every output 0 except cfg_ready=1; counters and packing register cleared. Reset mid-job abandons it silently, with no done pulse.
- Handshake: a byte transfers on s_valid&s_ready; a descriptor is accepted on cfg_valid&cfg_ready. A zero dimension goes IDLE→DONE with err=1, no writes and no tpu_in_valid.
- States: IDLE → LOAD_A → LOAD_B → FLUSH → START → WAIT_HI → WAIT_LO → DONE → IDLE.
- LOAD_A stream order: column-major, k outer 0..K-1, m inner 0..M-1. Exactly M*K bytes.
- LOAD_B stream order: row-major, k outer, n inner 0..N-1. Exactly K*N bytes.
- Lane packing:
  - Element m goes to lane m%4 of word A_index=(m/4)*K+k. Lane 0=[31:24], lane 3=[7:0].
  - B uses the same rule with n in place of m: B_index=(n/4)*K+k.
- Word write timing: a word is written when lane 3 is filled, or when the last element of the column/row is filled (m==M-1 or n==N-1).
  - Write occurs one cycle after the completing byte: wr_en=1 for one cycle, with index and data registered together.
  - Unfilled lanes are zero.
  - The packing register clears after each write.
- Back-pressure and phase transitions:
  - s_ready is held high; no back-pressure in load states. Idle cycles with s_valid=0 are legal and the counters hold.
  - After the final A byte: LOAD_B on the next cycle.
  - After the final B byte: FLUSH for one cycle, to let the last B write retire.
- A and B writes never occur in the same cycle.
- START: tpu_in_valid=1 for exactly one cycle, then WAIT_HI.
- WAIT_HI: on tpu_busy=1 go to WAIT_LO. After START_TIMEOUT cycles without busy, go to DONE with err=1.
- WAIT_LO: on tpu_busy=0 go to DONE.
- DONE: done=1 for one cycle, err valid that cycle, then IDLE.
- Index arithmetic: unsigned, computed by running adds (tile base += K), no multiplier. Maximum 63*255+254 = 16319, which fits in IDX_W=16.
- cfg_valid outside IDLE is ignored. Stream bytes outside load states are not accepted.

Test Plan:
- Odd-padding case:
  - Stimulus: K=2, M=3, N=5; A bytes 01,02,03,04,05,06; B bytes 10..19.
  - A writes: A[0]=01020300, A[1]=04050600.
  - B writes, in order: B[0]=10111213, B[2]=14000000, B[1]=15161718, B[3]=19000000.
  - Then tpu_in_valid with K/M/N=2/3/5.
- Exact-multiple case: K=1, M=4, N=4, bytes AA,BB,CC,DD then 01..04 → A[0]=AABBCCDD, B[0]=01020304, exactly two writes total.
- TPU handshake: tpu_busy rises 1 cycle after tpu_in_valid and falls 20 cycles later → done pulse 1 cycle after busy falls, err=0, cfg_ready=1 the cycle after.
- Stream gaps and large dims:
  - Stimulus: K=3, M=8, N=4; s_valid toggled 1010…
  - Expected: same words as the gap-free run, with indices A 0..5 and B 0..2.
  - Largest index check: K=255, M=N=252 → last A_index=62*255+254.
- Errors: cfg_M=0 → done&err 1 cycle after acceptance, no writes. tpu_busy held 0 → err=1 after 64 WAIT_HI cycles.
- Reset: assert rst mid-LOAD_B → next cycle IDLE, cfg_ready=1, all strobes 0. A new job afterwards produces correct indices starting at 0.

Source files
------------

// File: rtl/tpu_operand_loader.sv
// tpu_operand_loader: packs an A/B byte stream into 32-bit tiled TPU buffer words, then starts the TPU and reports done.
// Ports: cfg_* job descriptor handshake (K, M, N); s_* byte stream; A_*/B_* buffer write ports;
// tpu_in_valid/tpu_K/tpu_M/tpu_N start pulse and latched dims; tpu_busy from the TPU; done/err completion pulse.
module tpu_operand_loader #(
  parameter int IDX_W = 16,
  parameter int START_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [7:0]       cfg_K,
  input  logic [7:0]       cfg_M,
  input  logic [7:0]       cfg_N,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic             A_wr_en,
  output logic [IDX_W-1:0] A_index,
  output logic [31:0]      A_data_in,
  output logic             B_wr_en,
  output logic [IDX_W-1:0] B_index,
  output logic [31:0]      B_data_in,
  output logic             tpu_in_valid,
  output logic [7:0]       tpu_K,
  output logic [7:0]       tpu_M,
  output logic [7:0]       tpu_N,
  input  logic             tpu_busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, FLUSH, START, WAIT_HI, WAIT_LO, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] k, e, dim_e;
  logic [IDX_W-1:0] base, idx;
  logic [31:0] pack, word;
  logic [15:0] t;
  logic err_r, beat, accept, zero, last_e, last_k, wr, timeout;
  // e is the inner element (m in A, n in B); base is the running (e/4)*K tile offset
  always_comb begin
    dim_e = state == LOAD_A ? tpu_M : tpu_N;
    beat = s_valid & s_ready;
    accept = cfg_valid & cfg_ready;
    zero = cfg_K == 8'd0 || cfg_M == 8'd0 || cfg_N == 8'd0;
    last_e = e == dim_e - 8'd1;
    last_k = k == tpu_K - 8'd1;
    wr = beat & (last_e | (&e[1:0]));
    idx = base + IDX_W'(k);
    word = pack | ({s_data, 24'd0} >> {e[1:0], 3'd0});
    timeout = t == 16'(START_TIMEOUT - 1);
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = zero ? DONE : LOAD_A;
      LOAD_A:  if (beat && last_e && last_k) state_nx = LOAD_B;
      LOAD_B:  if (beat && last_e && last_k) state_nx = FLUSH;
      FLUSH:   state_nx = START;
      START:   state_nx = WAIT_HI;
      WAIT_HI: if (tpu_busy || timeout) state_nx = tpu_busy ? WAIT_LO : DONE;
      WAIT_LO: if (!tpu_busy) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    cfg_ready = state == IDLE;
    s_ready = state == LOAD_A || state == LOAD_B;
    tpu_in_valid = state == START;
    done = state == DONE;
    err = (state == DONE) & err_r;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      k <= '0;
      e <= '0;
      base <= '0;
      pack <= '0;
      t <= '0;
      err_r <= 1'b0;
      tpu_K <= '0;
      tpu_M <= '0;
      tpu_N <= '0;
      A_wr_en <= 1'b0;
      A_index <= '0;
      A_data_in <= '0;
      B_wr_en <= 1'b0;
      B_index <= '0;
      B_data_in <= '0;
    end else begin
      A_wr_en <= wr && state == LOAD_A;
      B_wr_en <= wr && state == LOAD_B;
      t <= state == WAIT_HI ? t + 16'd1 : 16'd0;
      if (state == WAIT_HI && !tpu_busy && timeout) err_r <= 1'b1;
      if (accept) begin
        tpu_K <= cfg_K;
        tpu_M <= cfg_M;
        tpu_N <= cfg_N;
        err_r <= zero;
        k <= '0;
        e <= '0;
        base <= '0;
        pack <= '0;
      end
      if (wr && state == LOAD_A) begin
        A_index <= idx;
        A_data_in <= word;
      end
      if (wr && state == LOAD_B) begin
        B_index <= idx;
        B_data_in <= word;
      end
      if (beat) begin
        pack <= wr ? 32'd0 : word;
        e <= last_e ? 8'd0 : e + 8'd1;
        k <= last_e ? (last_k ? 8'd0 : k + 8'd1) : k;
        base <= last_e ? '0 : (&e[1:0]) ? base + IDX_W'(tpu_K) : base;
      end
    end
  end
endmodule

// File: tb/tb_tpu_operand_loader.sv
// tb_tpu_operand_loader: table-driven and directed checks of the operand loader.
module tb_tpu_operand_loader;
  localparam int IDX_W = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_valid = 1'b0, s_valid = 1'b0, tpu_busy = 1'b0;
  logic [7:0] cfg_K = '0, cfg_M = '0, cfg_N = '0, s_data = '0;
  logic cfg_ready, s_ready, A_wr_en, B_wr_en, tpu_in_valid, done, err;
  logic [IDX_W-1:0] A_index, B_index;
  logic [31:0] A_data_in, B_data_in;
  logic [7:0] tpu_K, tpu_M, tpu_N;
  always #5 clk = ~clk;
  tpu_operand_loader #(.IDX_W(IDX_W), .START_TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_K(cfg_K), .cfg_M(cfg_M), .cfg_N(cfg_N),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .A_wr_en(A_wr_en), .A_index(A_index), .A_data_in(A_data_in),
    .B_wr_en(B_wr_en), .B_index(B_index), .B_data_in(B_data_in),
    .tpu_in_valid(tpu_in_valid), .tpu_K(tpu_K), .tpu_M(tpu_M), .tpu_N(tpu_N),
    .tpu_busy(tpu_busy), .done(done), .err(err)
  );
  logic [47:0] aq[$], bq[$];
  bit both_wr = 1'b0;
  always @(negedge clk) begin
    if (A_wr_en) aq.push_back({A_index, A_data_in});
    if (B_wr_en) bq.push_back({B_index, B_data_in});
    if (A_wr_en && B_wr_en) both_wr = 1'b1;
  end
  typedef struct packed {
    logic [7:0] k, m, n;
    logic gap;
    logic [39:0][7:0] bytes;
    logic [3:0] na, nb;
    logic [7:0][47:0] ea, eb;
  } vec_t;
  vec_t vecs[4];
  int n_vec = 0, n_err = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send_cfg(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n);
    cfg_valid = 1'b1;
    cfg_K = k;
    cfg_M = m;
    cfg_N = n;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, input bit gap);
    s_valid = 1'b1;
    s_data = b;
    @(negedge clk);
    s_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask
  task automatic wait_start();
    int w = 0;
    while (!tpu_in_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("start_seen", 64'(tpu_in_valid), 64'd1);
  endtask
  task automatic run_vec(input int id, input vec_t v);
    int a0 = aq.size();
    int b0 = bq.size();
    int nbytes = int'(v.m) * int'(v.k) + int'(v.k) * int'(v.n);
    send_cfg(v.k, v.m, v.n);
    for (int i = 0; i < nbytes; i++) send_byte(v.bytes[i], v.gap);
    wait_start();
    chk($sformatf("v%0d_dims", id), {tpu_K, tpu_M, tpu_N}, {v.k, v.m, v.n});
    tpu_busy = 1'b1;
    repeat (20) @(negedge clk);
    tpu_busy = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_done_err", id), {done, err}, 2'b10);
    @(negedge clk);
    chk($sformatf("v%0d_idle", id), {cfg_ready, done}, 2'b10);
    chk($sformatf("v%0d_a_count", id), aq.size() - a0, 64'(v.na));
    chk($sformatf("v%0d_b_count", id), bq.size() - b0, 64'(v.nb));
    for (int i = 0; i < int'(v.na); i++)
      chk($sformatf("v%0d_a%0d", id, i), (a0 + i < aq.size()) ? aq[a0 + i] : '1, v.ea[i]);
    for (int i = 0; i < int'(v.nb); i++)
      chk($sformatf("v%0d_b%0d", id, i), (b0 + i < bq.size()) ? bq[b0 + i] : '1, v.eb[i]);
  endtask
  initial begin
    int a0, b0, cnt;
    vecs[0] = '0;
    vecs[0].k = 8'd2; vecs[0].m = 8'd3; vecs[0].n = 8'd5;
    for (int i = 0; i < 6; i++) vecs[0].bytes[i] = 8'(i + 1);
    for (int i = 0; i < 10; i++) vecs[0].bytes[6 + i] = 8'(8'h10 + i);
    vecs[0].na = 4'd2; vecs[0].nb = 4'd4;
    vecs[0].ea[0] = {16'd0, 32'h01020300};
    vecs[0].ea[1] = {16'd1, 32'h04050600};
    vecs[0].eb[0] = {16'd0, 32'h10111213};
    vecs[0].eb[1] = {16'd2, 32'h14000000};
    vecs[0].eb[2] = {16'd1, 32'h15161718};
    vecs[0].eb[3] = {16'd3, 32'h19000000};
    vecs[1] = '0;
    vecs[1].k = 8'd1; vecs[1].m = 8'd4; vecs[1].n = 8'd4;
    vecs[1].bytes[0] = 8'hAA; vecs[1].bytes[1] = 8'hBB;
    vecs[1].bytes[2] = 8'hCC; vecs[1].bytes[3] = 8'hDD;
    for (int i = 0; i < 4; i++) vecs[1].bytes[4 + i] = 8'(i + 1);
    vecs[1].na = 4'd1; vecs[1].nb = 4'd1;
    vecs[1].ea[0] = {16'd0, 32'hAABBCCDD};
    vecs[1].eb[0] = {16'd0, 32'h01020304};
    vecs[2] = '0;
    vecs[2].k = 8'd3; vecs[2].m = 8'd8; vecs[2].n = 8'd4;
    for (int i = 0; i < 24; i++) vecs[2].bytes[i] = 8'(8'h20 + i);
    for (int i = 0; i < 12; i++) vecs[2].bytes[24 + i] = 8'(8'h40 + i);
    vecs[2].na = 4'd6; vecs[2].nb = 4'd3;
    vecs[2].ea[0] = {16'd0, 32'h20212223};
    vecs[2].ea[1] = {16'd3, 32'h24252627};
    vecs[2].ea[2] = {16'd1, 32'h28292A2B};
    vecs[2].ea[3] = {16'd4, 32'h2C2D2E2F};
    vecs[2].ea[4] = {16'd2, 32'h30313233};
    vecs[2].ea[5] = {16'd5, 32'h34353637};
    vecs[2].eb[0] = {16'd0, 32'h40414243};
    vecs[2].eb[1] = {16'd1, 32'h44454647};
    vecs[2].eb[2] = {16'd2, 32'h48494A4B};
    vecs[3] = vecs[2];
    vecs[3].gap = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {cfg_ready, s_ready, A_wr_en, B_wr_en, tpu_in_valid, done, err}, 7'b1000000);
    chk("reset_dims_idx", {tpu_K, tpu_M, tpu_N, A_index, B_index}, '0);
    rst = 1'b0;
    @(negedge clk);
    a0 = aq.size();
    b0 = bq.size();
    send_cfg(8'd2, 8'd0, 8'd3);
    chk("zero_dim_done_err", {done, err, tpu_in_valid}, 3'b110);
    @(negedge clk);
    chk("zero_dim_idle", {cfg_ready, done}, 2'b10);
    chk("zero_dim_no_writes", aq.size() - a0 + bq.size() - b0, 64'd0);
    for (int v = 0; v < 4; v++) run_vec(v, vecs[v]);
    a0 = aq.size();
    b0 = bq.size();
    send_cfg(8'd255, 8'd252, 8'd252);
    for (int i = 0; i < 255 * 252; i++) send_byte(8'(i), 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h80 + i), 1'b0);
    chk("large_a_count", aq.size() - a0, 64'd16065);
    chk("large_last_a_index", aq.size() > a0 ? aq[$][47:32] : '1, 64'(62 * 255 + 254));
    chk("large_b_first", bq.size() > b0 ? bq[b0] : '1, {16'd0, 32'h80818283});
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_outputs", {cfg_ready, s_ready, A_wr_en, B_wr_en, tpu_in_valid, done}, 6'b100000);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_no_done", {cfg_ready, done}, 2'b10);
    run_vec(4, vecs[0]);
    send_cfg(8'd1, 8'd1, 8'd1);
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    wait_start();
    cnt = 0;
    while (!done && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_cycles", 64'(cnt), 64'd65);
    chk("timeout_err", {done, err}, 2'b11);
    chk("timeout_a", aq[$], {16'd0, 32'h5A000000});
    chk("timeout_b", bq[$], {16'd0, 32'hA5000000});
    @(negedge clk);
    chk("timeout_idle", {cfg_ready, done}, 2'b10);
    chk("no_simultaneous_ab_write", 64'(both_wr), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
